// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: sequencer state
// encodings and requester port identifiers.
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      DMA_IDLE   = 2'd0,
      DMA_ACCESS = 2'd1,
      DMA_DONE   = 2'd2
   } dma_state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester ports plus the single data-memory port.
// The arbiter takes the slave view; requesters and memory sit on the master side.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);

   logic              req0;
   logic              req1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              we0;
   logic              we1;
   logic              ack0;
   logic              ack1;
   logic              err0;
   logic              err1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_access_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write_en;
   logic              mem_read;
   logic [DATA_W-1:0] mem_read_data;

   modport master (
      output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_read_data,
      input  ack0, ack1, err0, err1, rdata,
      input  mem_access_addr, mem_write_data, mem_write_en, mem_read
   );

   modport slave (
      input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_read_data,
      output ack0, ack1, err0, err1, rdata,
      output mem_access_addr, mem_write_data, mem_write_en, mem_read
   );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie, the port that was
// not granted last wins.
module rr_arb2
   import data_mem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = PORT0;
      if (req0 && req1)
         gnt_id = ~last_gnt;
      else if (req1)
         gnt_id = PORT1;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between two requesters; each access is
// a fixed IDLE -> ACCESS -> DONE sequence with round-robin grants.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 3
) (
   input logic              clk,
   input logic              reset,
   data_mem_arbiter_if.slave bus
);

   dma_state_t        state;
   dma_state_t        next_state;
   logic              last_gnt;
   logic              gnt_valid;
   logic              gnt_id;
   logic              txn_id;
   logic              txn_we;
   logic [ADDR_W-1:0] txn_addr;
   logic [DATA_W-1:0] txn_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              in_range;

   rr_arb2 u_rr_arb2 (
      .req0      (bus.req0),
      .req1      (bus.req1),
      .last_gnt  (last_gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Any address bit above the implemented depth marks the access as an error.
   assign in_range = (txn_addr[ADDR_W-1:DEPTH_LOG2] == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= DMA_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         DMA_IDLE:   if (gnt_valid) next_state = DMA_ACCESS;
         DMA_ACCESS: next_state = DMA_DONE;
         DMA_DONE:   next_state = DMA_IDLE;
         default:    next_state = DMA_IDLE;
      endcase
   end

   // last_gnt resets to port 1 so that port 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt  <= PORT1;
         txn_id    <= PORT0;
         txn_we    <= 1'b0;
         txn_addr  <= '0;
         txn_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         if (state == DMA_IDLE && gnt_valid) begin
            txn_id    <= gnt_id;
            txn_addr  <= (gnt_id == PORT1) ? bus.addr1  : bus.addr0;
            txn_wdata <= (gnt_id == PORT1) ? bus.wdata1 : bus.wdata0;
            txn_we    <= (gnt_id == PORT1) ? bus.we1    : bus.we0;
         end
         if (state == DMA_ACCESS) begin
            rdata_q  <= (!txn_we && in_range) ? bus.mem_read_data : '0;
            last_gnt <= txn_id;
         end
      end
   end

   always_comb begin
      bus.mem_access_addr = '0;
      bus.mem_write_data  = '0;
      bus.mem_write_en    = 1'b0;
      bus.mem_read        = 1'b0;
      bus.ack0            = 1'b0;
      bus.ack1            = 1'b0;
      bus.err0            = 1'b0;
      bus.err1            = 1'b0;
      bus.rdata           = '0;
      unique case (state)
         DMA_ACCESS: begin
            bus.mem_access_addr = txn_addr;
            bus.mem_write_data  = txn_wdata;
            bus.mem_write_en    = txn_we & in_range;
            bus.mem_read        = ~txn_we & in_range;
         end
         DMA_DONE: begin
            bus.ack0  = (txn_id == PORT0);
            bus.ack1  = (txn_id == PORT1);
            bus.err0  = (txn_id == PORT0) & ~in_range;
            bus.err1  = (txn_id == PORT1) & ~in_range;
            bus.rdata = rdata_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomized bench for data_mem_arbiter, checked against a
// transaction-level model of the memory contents and round-robin order.
module tb_data_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   logic clk = 1'b0;
   logic reset;

   data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory attached to the arbiter: combinational read, write on rising edge.
   logic [15:0] mem [8] = '{default: 16'h0000};
   assign bus.mem_read_data = mem[bus.mem_access_addr[2:0]];
   always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_access_addr[2:0]] <= bus.mem_write_data;

   // Reference model: expected memory contents and last served port.
   logic [15:0] ref_mem [8] = '{default: 16'h0000};
   int ref_last = 1;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic in_rng(input logic [15:0] a);
      return a < 16'd8;
   endfunction

   task automatic apply_stimulus(input int p, input logic r, input logic [15:0] a,
                                 input logic [15:0] d, input logic w);
      if (p == 0) begin
         bus.req0 = r; bus.addr0 = a; bus.wdata0 = d; bus.we0 = w;
      end else begin
         bus.req1 = r; bus.addr1 = a; bus.wdata1 = d; bus.we1 = w;
      end
   endtask

   task automatic model_txn(input int p, input logic [15:0] a, input logic [15:0] d, input logic w,
                            output logic [15:0] exp_rd, output logic exp_err);
      exp_err = !in_rng(a);
      exp_rd  = 16'h0000;
      if (in_rng(a)) begin
         if (w) ref_mem[a[2:0]] = d;
         else   exp_rd = ref_mem[a[2:0]];
      end
      ref_last = p;
   endtask

   // Checks the completion pulse, error flag and read data for a served port.
   task automatic check_done(input int p, input logic [15:0] er, input logic ee);
      check_output("done_ack", {bus.ack0, bus.ack1}, (p == 0) ? 2'b10 : 2'b01);
      check_output("done_err", {bus.err0, bus.err1}, (p == 0) ? {ee, 1'b0} : {1'b0, ee});
      check_output("done_rdata", bus.rdata, er);
      check_output("done_mem_quiet", {bus.mem_write_en, bus.mem_read}, 2'b00);
   endtask

   task automatic run_txn(input int p, input logic [15:0] a, input logic [15:0] d, input logic w);
      logic [15:0] er;
      logic        ee;
      apply_stimulus(p, 1'b1, a, d, w);
      tick;
      check_output("access_addr", bus.mem_access_addr, a);
      check_output("access_wdata", bus.mem_write_data, d);
      check_output("access_we", bus.mem_write_en, w && in_rng(a));
      check_output("access_rd", bus.mem_read, !w && in_rng(a));
      check_output("access_noack", {bus.ack0, bus.ack1}, 2'b00);
      tick;
      model_txn(p, a, d, w, er, ee);
      check_done(p, er, ee);
      apply_stimulus(p, 1'b0, a, d, w);
      tick;
      check_output("idle_noack", {bus.ack0, bus.ack1}, 2'b00);
   endtask

   initial begin
      logic [15:0] er;
      logic        ee;
      logic [15:0] ra [2];
      logic [15:0] rd [2];
      logic        rw [2];
      int          wp;
      int          lp;

      apply_stimulus(0, 1'b0, 16'h0, 16'h0, 1'b0);
      apply_stimulus(1, 1'b0, 16'h0, 16'h0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_flags", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_write_en, bus.mem_read}, 6'b0);
      check_output("rst_rdata", bus.rdata, 16'h0);
      check_output("rst_addr", bus.mem_access_addr, 16'h0);
      check_output("rst_wdata", bus.mem_write_data, 16'h0);
      reset = 1'b0;
      tick;

      $display("[TB] write/read addr 3");
      run_txn(0, 16'h0003, 16'hA5A5, 1'b1);
      run_txn(0, 16'h0003, 16'h0000, 1'b0);

      run_txn(1, 16'h0001, 16'h1111, 1'b1);
      run_txn(0, 16'h0002, 16'h2222, 1'b1);

      $display("[TB] continuous contention after reset");
      reset = 1'b1;
      tick;
      reset = 1'b0;
      ref_last = 1;
      tick;
      apply_stimulus(0, 1'b1, 16'h0001, 16'h0, 1'b0);
      apply_stimulus(1, 1'b1, 16'h0002, 16'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         wp = (ref_last == 0) ? 1 : 0;
         tick;
         check_output("rr_access_addr", bus.mem_access_addr, (wp == 1) ? 16'h2 : 16'h1);
         tick;
         model_txn(wp, (wp == 1) ? 16'h2 : 16'h1, 16'h0, 1'b0, er, ee);
         check_done(wp, er, ee);
         if (k == 3) begin
            apply_stimulus(0, 1'b0, 16'h0001, 16'h0, 1'b0);
            apply_stimulus(1, 1'b0, 16'h0002, 16'h0, 1'b0);
         end
         tick;
         check_output("rr_idle_noack", {bus.ack0, bus.ack1}, 2'b00);
      end

      $display("[TB] out of range");
      run_txn(1, 16'h0008, 16'h0000, 1'b0);
      run_txn(0, 16'h8003, 16'hFFFF, 1'b1);
      run_txn(1, 16'h0003, 16'h0000, 1'b0);

      $display("[TB] reset during access");
      apply_stimulus(1, 1'b1, 16'h0005, 16'hBEEF, 1'b1);
      tick;
      check_output("rstmid_we_before", bus.mem_write_en, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_output("rstmid_we_drop", bus.mem_write_en, 1'b0);
      check_output("rstmid_noack", {bus.ack0, bus.ack1}, 2'b00);
      apply_stimulus(1, 1'b0, 16'h0005, 16'hBEEF, 1'b1);
      tick;
      check_output("rstmid_noack_edge", {bus.ack0, bus.ack1}, 2'b00);
      reset = 1'b0;
      ref_last = 1;
      tick;
      check_output("rstmid_noack_after", {bus.ack0, bus.ack1, bus.mem_write_en}, 3'b000);
      run_txn(0, 16'h0005, 16'h0000, 1'b0);

      $display("[TB] write port 0 then read port 1");
      run_txn(0, 16'h0007, 16'h1234, 1'b1);
      run_txn(1, 16'h0007, 16'h0000, 1'b0);

      $display("[TB] held request re-issues");
      apply_stimulus(0, 1'b1, 16'h0006, 16'h0606, 1'b1);
      for (int r = 0; r < 2; r++) begin
         tick;
         check_output("reissue_we", {bus.mem_write_en, bus.mem_access_addr}, {1'b1, 16'h0006});
         tick;
         model_txn(0, 16'h0006, 16'h0606, 1'b1, er, ee);
         check_done(0, er, ee);
         if (r == 1) apply_stimulus(0, 1'b0, 16'h0006, 16'h0606, 1'b1);
         tick;
         check_output("reissue_idle", {bus.ack0, bus.ack1}, 2'b00);
      end
      run_txn(1, 16'h0006, 16'h0000, 1'b0);

      $display("[TB] random single transactions");
      for (int n = 0; n < 24; n++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
         run_txn(int'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("[TB] random contention pairs");
      for (int n = 0; n < 8; n++) begin
         for (int q = 0; q < 2; q++) begin
            ra[q] = 16'($urandom_range(0, 9));
            rd[q] = 16'($urandom);
            rw[q] = 1'($urandom_range(0, 1));
            apply_stimulus(q, 1'b1, ra[q], rd[q], rw[q]);
         end
         wp = (ref_last == 0) ? 1 : 0;
         lp = 1 - wp;
         for (int s = 0; s < 2; s++) begin
            int p;
            p = (s == 0) ? wp : lp;
            tick;
            check_output("pair_access_addr", bus.mem_access_addr, ra[p]);
            tick;
            model_txn(p, ra[p], rd[p], rw[p], er, ee);
            check_done(p, er, ee);
            apply_stimulus(p, 1'b0, ra[p], rd[p], rw[p]);
            tick;
            check_output("pair_idle", {bus.ack0, bus.ack1}, 2'b00);
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
